// File: rtl/sort_checker.sv
// Waits for the CPU fetch PC to park in a spin loop, then scans an array in data memory and reports ordering.
// Optional SORT_CHECKER_SUM_EN: full-length scan with a zero-extended element checksum on sum.
module sort_checker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 100000,
  parameter int HALT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        count,
  input  logic                    descending,
  input  logic                    is_signed,
  input  logic [31:0]             pc,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [CNT_W-1:0]        err_index,
  output logic [31:0]             cycles,
  output logic [DATA_W+CNT_W-1:0] sum
);

  localparam int STEP   = DATA_W / 8;
  localparam int HALT_W = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                desc_q, desc_d;
  logic                sgn_q, sgn_d;
  logic [31:0]         cycles_q, cycles_d, cyc_inc;
  logic [HALT_W-1:0]   halt_q, halt_d, halt_nx;
  logic [31:0]         pc_q;
  logic [CNT_W-1:0]    rd_idx_q, rd_idx_d;
  logic                rvld_q;
  logic [CNT_W-1:0]    ridx_q;
  logic [DATA_W-1:0]   prev_q;
  logic [CNT_W-1:0]    err_q, err_d;
  logic                pass_q, pass_d;
  logic                tmo_q, tmo_d;
  logic                vseen_q, vseen_d;
  logic                cmp_lt, cmp_gt, viol, last, scan_end, issue;
`ifdef SORT_CHECKER_SUM_EN
  logic [DATA_W+CNT_W-1:0] sum_q, sum_d;
`endif

  // Element k arrives the cycle after its read; element 0 has no predecessor.
  assign cmp_lt = sgn_q ? ($signed(mem_rdata) < $signed(prev_q)) : (mem_rdata < prev_q);
  assign cmp_gt = sgn_q ? ($signed(mem_rdata) > $signed(prev_q)) : (mem_rdata > prev_q);
  assign viol   = rvld_q && (ridx_q != '0) && (desc_q ? cmp_gt : cmp_lt);
  assign last   = rvld_q && (ridx_q == count_q - CNT_W'(1));

`ifdef SORT_CHECKER_SUM_EN
  assign issue    = (state_q == S_SCAN) && (rd_idx_q < count_q);
  assign scan_end = (count_q == '0) || last;
  assign sum      = sum_q;
`else
  // The read that would overlap the violating return is suppressed.
  assign issue    = (state_q == S_SCAN) && (rd_idx_q < count_q) && !viol;
  assign scan_end = (count_q == '0) || last || viol;
  assign sum      = '0;
`endif

  assign mem_rd    = issue;
  assign mem_addr  = issue ? addr_q : '0;
  assign busy      = (state_q == S_RUN) || (state_q == S_SCAN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign timeout   = tmo_q;
  assign err_index = err_q;
  assign cycles    = cycles_q;

  assign cyc_inc = (cycles_q == '1) ? cycles_q : cycles_q + 32'd1;
  assign halt_nx = (pc == pc_q) ? halt_q + HALT_W'(1) : '0;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    desc_d   = desc_q;
    sgn_d    = sgn_q;
    cycles_d = cycles_q;
    halt_d   = halt_q;
    rd_idx_d = rd_idx_q;
    err_d    = err_q;
    pass_d   = pass_q;
    tmo_d    = tmo_q;
    vseen_d  = vseen_q;
`ifdef SORT_CHECKER_SUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d   = base_addr;
          count_d  = count;
          desc_d   = descending;
          sgn_d    = is_signed;
          cycles_d = '0;
          halt_d   = '0;
          rd_idx_d = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          tmo_d    = 1'b0;
          vseen_d  = 1'b0;
`ifdef SORT_CHECKER_SUM_EN
          sum_d    = '0;
`endif
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cycles_d = cyc_inc;
        halt_d   = halt_nx;
        // Watchdog is tested first so it wins a same-cycle tie with halt detection.
        if (cyc_inc >= 32'(MAX_CYCLES)) begin
          tmo_d   = 1'b1;
          pass_d  = 1'b0;
          state_d = S_DONE;
        end else if (halt_nx >= HALT_W'(HALT_CYCLES)) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_W'(STEP);
          rd_idx_d = rd_idx_q + CNT_W'(1);
        end
`ifdef SORT_CHECKER_SUM_EN
        if (rvld_q) sum_d = sum_q + {{CNT_W{1'b0}}, mem_rdata};
`endif
        if (viol && !vseen_q) begin
          err_d   = ridx_q;
          vseen_d = 1'b1;
        end
        if (scan_end) begin
          pass_d  = !(vseen_q || viol);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      count_q  <= '0;
      desc_q   <= 1'b0;
      sgn_q    <= 1'b0;
      cycles_q <= '0;
      halt_q   <= '0;
      pc_q     <= '0;
      rd_idx_q <= '0;
      rvld_q   <= 1'b0;
      ridx_q   <= '0;
      prev_q   <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      vseen_q  <= 1'b0;
`ifdef SORT_CHECKER_SUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      desc_q   <= desc_d;
      sgn_q    <= sgn_d;
      cycles_q <= cycles_d;
      halt_q   <= halt_d;
      pc_q     <= pc;
      rd_idx_q <= rd_idx_d;
      rvld_q   <= issue;
      if (issue) ridx_q <= rd_idx_q;
      if (rvld_q) prev_q <= mem_rdata;
      err_q    <= err_d;
      pass_q   <= pass_d;
      tmo_q    <= tmo_d;
      vseen_q  <= vseen_d;
`ifdef SORT_CHECKER_SUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_sort_checker.sv
// Scoreboard bench for sort_checker: a memory responder, a reference ordering model and a done-triggered monitor.
module tb_sort_checker;
`ifdef SORT_CHECKER_SUM_EN
  localparam bit SUMEN = 1'b1;
`else
  localparam bit SUMEN = 1'b0;
`endif
  localparam int MAXC = 500;
  localparam int HALT = 16;

  logic        clk = 1'b0;
  logic        rst, start, desc, sgn;
  logic [31:0] base, pc;
  logic [15:0] count;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        busy, done, pass, timeout;
  logic [15:0] err_index;
  logic [31:0] cycles;
  logic [47:0] sum;

  always #5 clk = ~clk;

  sort_checker #(.ADDR_W(32), .DATA_W(32), .CNT_W(16), .MAX_CYCLES(MAXC), .HALT_CYCLES(HALT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .count(count),
    .descending(desc), .is_signed(sgn), .pc(pc), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_index(err_index), .cycles(cycles), .sum(sum)
  );

  typedef struct {
    bit          pass;
    bit          tmo;
    int unsigned err;
    int unsigned nreads;
    logic [47:0] sum;
    int unsigned cyc_lo;
    int unsigned cyc_hi;
    logic [31:0] base;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] addrs[$];
  int          checks = 0, errors = 0, nrd = 0, n_inv = 0;
  logic        pend = 1'b0, done_prev = 1'b0;
  logic [31:0] pa = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [31:0] b, input logic [31:0] arr[$], input bit d,
                                 input bit s, input int p, input bit tmo);
    exp_t e;
    e.base = b;
    if (tmo) begin
      e.pass = 0; e.tmo = 1; e.err = 0; e.nreads = 0; e.sum = '0;
      e.cyc_lo = MAXC; e.cyc_hi = MAXC;
      return e;
    end
    e.tmo = 0; e.err = 0; e.sum = '0;
    for (int k = 1; k < arr.size(); k++) begin
      longint cur, prv;
      cur = s ? longint'($signed(arr[k]))   : longint'(arr[k]);
      prv = s ? longint'($signed(arr[k-1])) : longint'(arr[k-1]);
      if (d ? (cur > prv) : (cur < prv)) begin
        e.err = k;
        break;
      end
    end
    e.pass = (e.err == 0);
    if (SUMEN) begin
      e.nreads = arr.size();
      foreach (arr[i]) e.sum = e.sum + {16'h0, arr[i]};
    end else begin
      e.nreads = (e.err != 0) ? e.err + 1 : arr.size();
    end
    e.cyc_lo = p + HALT - 1;
    e.cyc_hi = p + HALT + 1;
    return e;
  endfunction

  // Memory responder, read tracker, invariants and scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      pend = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (start && !busy) begin
        nrd = 0;
        addrs.delete();
      end
      pend = mem_rd;
      pa   = mem_addr;
      if (mem_rd) begin
        nrd++;
        addrs.push_back(mem_addr);
      end
      if ((done && busy) || (mem_rd && !busy)) begin
        errors++;
        if (n_inv < 5) $display("FAIL invariant: done=%0b busy=%0b mem_rd=%0b", done, busy, mem_rd);
        n_inv++;
      end
      if (done && !done_prev) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done with no expected result");
        end else begin
          exp_t e;
          bit   ok;
          int   bad;
          e = expq.pop_front();
          chk("pass", pass, e.pass);
          chk("timeout", timeout, e.tmo);
          chk("err_index", err_index, e.err);
          chk("reads", nrd, e.nreads);
          chk("sum", sum, e.sum);
          checks++;
          if (cycles < e.cyc_lo || cycles > e.cyc_hi) begin
            errors++;
            $display("FAIL cycles: got %0d expected %0d..%0d", cycles, e.cyc_lo, e.cyc_hi);
          end
          ok = 1; bad = 0;
          foreach (addrs[i]) if (ok && addrs[i] !== e.base + 32'(4 * i)) begin ok = 0; bad = i; end
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL rd_addr[%0d]: got %0h expected %0h", bad, addrs[bad], e.base + 32'(4 * bad));
          end
        end
      end
      done_prev = done;
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rdata = (pend && mem.exists(pa)) ? mem[pa] : 32'h0;
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err_index"}, err_index, 0);
    chk({tag, "_cycles"}, cycles, 0);
    chk({tag, "_sum"}, sum, 0);
  endtask

  task automatic load(input logic [31:0] b, input logic [31:0] arr[$]);
    mem.delete();
    foreach (arr[i]) mem[b + 32'(4 * i)] = arr[i];
    base  = b;
    count = 16'(arr.size());
  endtask

  // p: RUN cycles during which pc keeps moving before it parks; poke: extra start while busy.
  task automatic run_case(input logic [31:0] b, input logic [31:0] arr[$], input bit d, input bit s,
                          input int p, input bit tmo, input bit poke);
    int j;
    load(b, arr);
    expq.push_back(model(b, arr, d, s, p, tmo));
    desc = d; sgn = s;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (tmo || j < p) begin
        pc = pc + 32'd4;
        j++;
      end
      if (poke && c == 3) begin start = 1'b1; base = 32'h0; count = 16'd0; end
      if (poke && c == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_wait: got done=0 expected done=1 within 3000 cycles");
      expq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] q[$];
    rst = 1'b0; start = 1'b0; desc = 1'b0; sgn = 1'b0;
    base = '0; count = '0; pc = 32'h400;
    #23;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    q = {32'd1, 32'd2, 32'd3, 32'd5, 32'd5, 32'd9};
    run_case(32'h1000, q, 0, 0, 200, 0, 1);
    q = {32'd4, 32'd7, 32'd6, 32'd8};
    run_case(32'h2000, q, 0, 0, 5, 0, 0);
    q = {32'hFFFF_FFFF, 32'd0, 32'd1};
    run_case(32'h3000, q, 0, 1, 3, 0, 0);
    run_case(32'h3000, q, 0, 0, 3, 0, 0);
    run_case(32'h3000, q, 1, 0, 3, 0, 0);
    q = {32'd1, 32'd2};
    run_case(32'h0, q, 0, 0, 0, 1, 0);
    q.delete();
    run_case(32'h40, q, 0, 0, 0, 0, 0);
    q = {32'd3, 32'd3};
    run_case(32'hFFFF_FFFC, q, 0, 0, 2, 0, 0);

    // Reset while the scan is streaming, then a clean run.
    q = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10};
    load(32'h500, q);
    desc = 1'b0; sgn = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && !mem_rd; c++) begin
      @(posedge clk); #1;
    end
    chk("midscan_rd_seen", mem_rd, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_zero("midscan");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    q = {32'd9, 32'd8, 32'd7};
    run_case(32'h600, q, 1, 0, 1, 0, 0);

    for (int r = 0; r < 12; r++) begin
      int n;
      bit d;
      q.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++)
        q.push_back(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 50)));
      d = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        q.sort();
        if (d) q.reverse();
      end
      run_case({$urandom} & 32'hFFFF_FFFC, q, d, 1'($urandom_range(0, 1)),
               $urandom_range(0, 40), 0, 0);
    end

    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
